// File: rtl/burst_memory.sv
// Single-port word RAM with wrapping bursts, byte strobes and a back-pressured read channel.
// Commands whose start address falls outside the array are rejected with a one-cycle err_o pulse.
//
// state    | meaning
// ST_IDLE  | waiting for a command; ready_o high once out of reset
// ST_WRITE | accepting len+1 write beats on the wvalid/wready channel
// ST_READ  | presenting len+1 registered read beats on the rvalid/rready channel
module burst_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    wr_rd_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rlast_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BEAT_W = LEN_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  out_of_reset_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic                  done_q;
  logic                  err_q;

  logic                  cmd_accept;
  logic                  addr_ok;
  logic                  last_beat;
  logic                  r_beat;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [BEAT_W-1:0]     beat_next;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;

  // ready is held low until the first clock after reset release
  assign cmd_accept = valid_i & out_of_reset_q & (state_q == ST_IDLE);
  assign addr_ok    = ({1'b0, addr_i} < DEPTH_EXT);
  assign last_beat  = (beat_q == {1'b0, len_q});
  assign r_beat     = (state_q == ST_READ) & rvalid_q & rready_i;
  assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
  assign beat_next  = beat_q + BEAT_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept && addr_ok) begin
          state_d = wr_rd_i ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wvalid_i && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (r_beat && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o   = 1'b0;
    wready_o  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = addr_next;
    case (state_q)
      ST_IDLE: begin
        ready_o = out_of_reset_q;
        if (cmd_accept && addr_ok && !wr_rd_i) begin
          mem_re    = 1'b1;
          mem_raddr = addr_i;
        end
      end
      ST_WRITE: begin
        wready_o = 1'b1;
        mem_we   = wvalid_i;
      end
      ST_READ: begin
        mem_re = r_beat & ~last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_of_reset_q <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      beat_q         <= '0;
      rvalid_q       <= 1'b0;
      rlast_q        <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      out_of_reset_q <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            if (!addr_ok) begin
              err_q <= 1'b1;
            end else begin
              addr_q <= addr_i;
              len_q  <= len_i;
              beat_q <= '0;
              if (!wr_rd_i) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (len_i == '0);
              end
            end
          end
        end
        ST_WRITE: begin
          if (wvalid_i) begin
            addr_q <= addr_next;
            beat_q <= beat_next;
            if (last_beat) begin
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (r_beat) begin
            if (last_beat) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              addr_q  <= addr_next;
              beat_q  <= beat_next;
              rlast_q <= (beat_next == {1'b0, len_q});
            end
          end
        end
        default: ;
      endcase
    end
  end

  // storage has no reset so it can map onto a RAM macro
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[addr_q][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (mem_re) begin
      rdata_q <= mem_q[mem_raddr];
    end
  end

  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;
  assign rdata_o  = rdata_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_burst_memory.sv
// Bench for burst_memory: table of write/read bursts against a reference memory model,
// plus hand sequences for rejected commands and reset during a read burst.
module tb_burst_memory;

  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int LW    = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic          wr_rd_i;
  logic [AW-1:0] addr_i;
  logic [LW-1:0] len_i;
  logic          wvalid_i;
  logic          wready_o;
  logic [DW-1:0] wdata_i;
  logic [3:0]    wstrb_i;
  logic          rvalid_o;
  logic          rready_i;
  logic [DW-1:0] rdata_o;
  logic          rlast_o;
  logic          done_o;
  logic          err_o;

  burst_memory #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .wr_rd_i (wr_rd_i),
    .addr_i  (addr_i),
    .len_i   (len_i),
    .wvalid_i(wvalid_i),
    .wready_o(wready_o),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .rvalid_o(rvalid_o),
    .rready_i(rready_i),
    .rdata_o (rdata_o),
    .rlast_o (rlast_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [15:0] rpat;
    bit          use_exp;
    logic [31:0] exp0;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } rexp_t;

  vec_t        vecs [13];
  rexp_t       exp_q [$];
  logic [31:0] model_mem [0:DEPTH-1];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap_inc(input int a);
    return (a == DEPTH - 1) ? 0 : a + 1;
  endfunction

  task automatic run_write(input int addr, input int len, input logic [31:0] data0,
                           input logic [3:0] strb);
    int          a;
    logic [31:0] wd;
    @(negedge clk_i);
    valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 8'(addr); len_i = 4'(len);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      check("wr_ready", 32'(wready_o), 32'd1);
      wd = data0 + 32'(i);
      wvalid_i = 1'b1; wdata_i = wd; wstrb_i = strb;
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
      end
      a = wrap_inc(a);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    wvalid_i = 1'b0;
    check("wr_done", 32'(done_o), 32'd1);
    check("wr_ready_after", 32'(ready_o), 32'd1);
    check("wr_wready_off", 32'(wready_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("wr_done_once", 32'(done_o), 32'd0);
  endtask

  task automatic run_read(input int addr, input int len, input logic [15:0] rpat,
                          input bit use_exp, input logic [31:0] exp0);
    int          a;
    int          beats;
    int          cyc;
    int          ones;
    int          exp_cyc;
    bit          have_held;
    bit          r;
    logic [31:0] held;
    rexp_t       e;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      e.data = (i == 0 && use_exp) ? exp0 : model_mem[a];
      e.last = (i == len);
      exp_q.push_back(e);
      a = wrap_inc(a);
    end
    ones = 0; exp_cyc = 0;
    for (int c = 0; c < 64; c++) begin
      r = (c < 16) ? rpat[c] : 1'b1;
      if (r) ones++;
      if (ones == len + 1) begin
        exp_cyc = c + 1;
        break;
      end
    end
    @(negedge clk_i);
    valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 8'(addr); len_i = 4'(len); rready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("rd_latency", 32'(rvalid_o), 32'd1);
    beats = 0; cyc = 0; have_held = 1'b0; held = '0;
    while (beats <= len && cyc < 64) begin
      rready_i = (cyc < 16) ? rpat[cyc] : 1'b1;
      if (have_held) check("rd_hold", rdata_o, held);
      if (rvalid_o && rready_i) begin
        if (exp_q.size() == 0) begin
          check("rd_sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rdata_o, e.data);
          check("rd_last", 32'(rlast_o), 32'(e.last));
        end
        beats++;
        have_held = 1'b0;
      end else if (rvalid_o) begin
        held = rdata_o;
        have_held = 1'b1;
      end else begin
        check("rd_gap", 32'(rvalid_o), 32'd1);
      end
      cyc++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rready_i = 1'b0;
    check("rd_beats", 32'(beats), 32'(len + 1));
    check("rd_cycles", 32'(cyc), 32'(exp_cyc));
    check("rd_rvalid_off", 32'(rvalid_o), 32'd0);
    check("rd_done", 32'(done_o), 32'd1);
    check("rd_ready_after", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    check("rd_done_once", 32'(done_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 16,  3,  32'h0000_00A0, 4'hF, 16'hFFFF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 16,  3,  32'h0,         4'h0, 16'hFFFF, 1'b1, 32'h0000_00A0};
    vecs[2]  = '{1'b1, 5,   0,  32'h1122_3344, 4'hF, 16'hFFFF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5,   0,  32'hFFFF_FFFF, 4'h5, 16'hFFFF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 5,   0,  32'h0,         4'h0, 16'hFFFF, 1'b1, 32'h11FF_33FF};
    vecs[5]  = '{1'b1, 198, 3,  32'h0000_0001, 4'hF, 16'hFFFF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 198, 3,  32'h0,         4'h0, 16'hFFFF, 1'b1, 32'h0000_0001};
    vecs[7]  = '{1'b0, 0,   0,  32'h0,         4'h0, 16'hFFFF, 1'b1, 32'h0000_0003};
    vecs[8]  = '{1'b0, 1,   0,  32'h0,         4'h0, 16'hFFFF, 1'b1, 32'h0000_0004};
    vecs[9]  = '{1'b1, 32,  2,  32'h0000_0100, 4'hF, 16'hFFFF, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32,  2,  32'h0,         4'h0, 16'hFFF4, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 100, 15, 32'h0000_5000, 4'hF, 16'hFFFF, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 100, 15, 32'h0,         4'h0, 16'hFFFF, 1'b0, 32'h0};

    rst_ni = 1'b0; valid_i = 1'b0; wr_rd_i = 1'b0; addr_i = '0; len_i = '0;
    wvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; rready_i = 1'b0;

    #12;
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_wready", 32'(wready_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_rlast", 32'(rlast_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready_release", 32'(ready_o), 32'd1);

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].wr) run_write(vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].strb);
      else run_read(vecs[v].addr, vecs[v].len, vecs[v].rpat, vecs[v].use_exp, vecs[v].exp0);
    end

    // rejected commands: start address at or beyond DEPTH, with write beats offered
    for (int k = 0; k < 3; k++) begin
      int bad;
      bad = (k == 0) ? 200 : (k == 1) ? 250 : 255;
      @(negedge clk_i);
      valid_i = 1'b1; wr_rd_i = (k != 1); addr_i = 8'(bad); len_i = 4'd3;
      wvalid_i = 1'b1; wdata_i = 32'hDEAD_BEEF; wstrb_i = 4'hF;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("err_pulse", 32'(err_o), 32'd1);
      check("err_ready", 32'(ready_o), 32'd1);
      check("err_wready", 32'(wready_o), 32'd0);
      check("err_rvalid", 32'(rvalid_o), 32'd0);
      check("err_done", 32'(done_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      wvalid_i = 1'b0;
      check("err_once", 32'(err_o), 32'd0);
      check("err_wready2", 32'(wready_o), 32'd0);
    end
    run_read(16, 3, 16'hFFFF, 1'b1, 32'h0000_00A0);

    // reset in the middle of a read burst
    @(negedge clk_i);
    valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 8'd100; len_i = 4'd7; rready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("mid_beat0", rdata_o, 32'h0000_5000);
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_beat1", rdata_o, 32'h0000_5001);
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_beat2_valid", 32'(rvalid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rvalid", 32'(rvalid_o), 32'd0);
    check("mid_rlast", 32'(rlast_o), 32'd0);
    check("mid_rdata", rdata_o, 32'd0);
    check("mid_ready", 32'(ready_o), 32'd0);
    check("mid_done", 32'(done_o), 32'd0);
    rready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_ready_release", 32'(ready_o), 32'd1);
    check("mid_no_done", 32'(done_o), 32'd0);
    run_read(100, 3, 16'hFFFF, 1'b1, 32'h0000_5000);
    run_read(16, 3, 16'hFFFF, 1'b0, 32'h0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised synchronous single-port RAM. It is the next generation of the team's simple valid/ready memory.
- Adds burst transfers with auto-incrementing, wrapping addresses, per-byte write strobes, and a read channel with back-pressure.
- Adds an error response for out-of-range addresses.
- Sits between a testbench/bus master and storage. The command, write-data and read-data channels are independent valid/ready handshakes.

Parameters:
DATA_WIDTH  32  data bits per word; must be a multiple of 8
DEPTH  256  number of words; need not be a power of two
ADDR_WIDTH  8  address bits; 2**ADDR_WIDTH >= DEPTH
LEN_WIDTH  4  burst length field width; burst = len_i+1 beats (1..2**LEN_WIDTH)

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_ni  in  1  asynchronous, active-low reset
valid_i  in  1  command valid
ready_o  out  1  command ready; high only in IDLE
wr_rd_i  in  1  1 = write burst, 0 = read burst; sampled at command accept
addr_i  in  ADDR_WIDTH  start address; sampled at accept
len_i  in  LEN_WIDTH  beats minus one; sampled at accept
wvalid_i  in  1  write beat valid
wready_o  out  1  write beat ready; high only in WRITE
wdata_i  in  DATA_WIDTH  write data
wstrb_i  in  DATA_WIDTH/8  byte enables; bit k writes byte k
rvalid_o  out  1  read beat valid
rready_i  in  1  read beat accepted by consumer
rdata_o  out  DATA_WIDTH  read data; registered
rlast_o  out  1  high with the final read beat
done_o  out  1  one-cycle pulse on burst completion
err_o  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State goes to IDLE.
  - ready_o=0 while rst_ni is low; ready_o=1 from the first clock after release.
  - wready_o=0, rvalid_o=0, rdata_o=0, rlast_o=0, done_o=0, err_o=0; internal address and beat counter cleared.
  - Memory contents are NOT cleared (RAM-inferable). Reads of never-written locations are X.
- FSM states IDLE, WRITE, READ.
  - Command accept = valid_i & ready_o at a rising edge.
- IDLE, on accept:
  - If addr_i >= DEPTH: err_o pulses the next cycle, state stays IDLE, no memory access.
  - If addr_i < DEPTH: latch address and len, clear the beat counter, go to WRITE or READ per wr_rd_i.
  - The start address alone is range-checked; burst beats never error.
- WRITE:
  - wready_o=1. Each edge with wvalid_i high writes the enabled bytes of wdata_i to mem[addr], then the address increments.
  - wstrb_i=0 still consumes a beat but changes no bytes.
  - After beat len+1: go to IDLE, done_o=1 for one cycle, ready_o=1 in that same cycle.
- READ:
  - On the accept edge, rdata_o <= mem[start], rvalid_o <= 1, and rlast_o <= (len==0).
  - Latency from accept to first valid beat: 1 cycle.
  - rdata_o, rvalid_o and rlast_o hold stable while rready_i is low.
  - On rvalid_o & rready_i for a non-final beat: the address increments and rdata_o loads the next word on the same edge. Streaming runs at 1 beat/cycle with rready_i held high.
  - On the final beat handshake: rvalid_o=0, rlast_o=0, go to IDLE, done_o pulses.
- Address increment wraps from DEPTH-1 to 0 (not to 2**ADDR_WIDTH-1).
- Signals outside their state are ignored:
  - valid_i while busy: held off by ready_o=0; the master must keep the command stable.
  - wvalid_i outside WRITE and rready_i outside READ: ignored.
- Reset mid-burst aborts the burst:
  - Beats already written remain in memory.
  - No done_o and no partial rlast_o are issued.
- Width rules:
  - Beat counter is LEN_WIDTH+1 bits, so len=all-ones gives 2**LEN_WIDTH beats with no overflow.
  - Address compare against DEPTH is unsigned.

Test Plan:
1. Reset, then write burst addr=0x10, len=3, data 0xA0..A3, wstrb=0xF; read back addr=0x10, len=3 with rready=1 -> rvalid 4 consecutive cycles, data A0,A1,A2,A3, rlast on 4th, done_o pulses once after each burst.
2. Byte strobes: write 0x11223344 to addr 5, then write 0xFFFFFFFF with wstrb=0x5 -> read returns 0x11FF33FF.
3. Wrap: DEPTH=200, write len=3 at addr 198 data 1,2,3,4 -> read addr 198 len=3 returns 1,2,3,4; single read addr 0 returns 3 and addr 1 returns 4.
4. Back-pressure: read len=2 with rready toggling 0,0,1,0,1,1 -> rdata held stable during low cycles, 3 beats delivered in order, no beat lost or duplicated.
5. Error: DEPTH=200, command addr=250 -> err_o pulse 1 cycle, no wready/rvalid, ready_o stays 1, memory unchanged.
6. Reset mid-read (rst_ni low after beat 2 of len=7) -> rvalid_o, rlast_o and rdata_o go 0 immediately; after release ready_o=1, and a prior write's data is still readable.
